// File: rtl/data_producer_pkg.sv
// Shared types and constants for the data_producer pattern source.
// Holds the FSM state encoding, the data and beat-count widths, the LFSR tap
// mask and the LFSR step function used by data_pattern_gen.
package data_producer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } producer_state_t;

  localparam int DATA_W     = 8;
  localparam int BEAT_CNT_W = 16;

  // Tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 feed the XOR).
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

  // One Fibonacci LFSR step: shift left, feed the tap parity into bit 0.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/data_producer_if.sv
// Bus bundle between the pattern source and its consumer.
// Signals:
//   i_Start, i_Stop   run request / synchronous abort (driven by the consumer side)
//   o_Output_Data     8-bit beat data
//   o_Data_Valid      beat qualifier
//   o_Busy            high while a run is in progress (BURST or GAP)
//   o_Done            one-cycle pulse at normal run completion
//   o_Beat_Count      beats emitted since the last start
// Modports: master = producer, slave = consumer/controller.
interface data_producer_if;
  import data_producer_pkg::*;

  logic                  i_Start;
  logic                  i_Stop;
  logic [DATA_W-1:0]     o_Output_Data;
  logic                  o_Data_Valid;
  logic                  o_Busy;
  logic                  o_Done;
  logic [BEAT_CNT_W-1:0] o_Beat_Count;

  modport master (
    input  i_Start, i_Stop,
    output o_Output_Data, o_Data_Valid, o_Busy, o_Done, o_Beat_Count
  );

  modport slave (
    output i_Start, i_Stop,
    input  o_Output_Data, o_Data_Valid, o_Busy, o_Done, o_Beat_Count
  );

endinterface

// File: rtl/data_pattern_gen.sv
// Pattern register for data_producer. Holds the value of the NEXT beat to be
// presented; o_seed gives the (possibly sanitised) first value of a run so
// the producer can present it on the load edge while this register moves on.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   i_load        start of run: register <= step(seed)
//   i_advance     a beat was taken: register <= step(register)
//   o_seed        first beat value of a run
//   o_value       next beat value
// Build option: DATA_PRODUCER_LFSR_EN selects an 8-bit Fibonacci LFSR
// (seed 0 forced to 1); otherwise a counter advancing by STEP.
module data_pattern_gen
  import data_producer_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h00,
  parameter logic [7:0] STEP = 8'h01
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_load,
  input  logic              i_advance,
  output logic [DATA_W-1:0] o_seed,
  output logic [DATA_W-1:0] o_value
);

`ifdef DATA_PRODUCER_LFSR_EN
  // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
  localparam logic [DATA_W-1:0] C_SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  function automatic logic [DATA_W-1:0] step_fn(input logic [DATA_W-1:0] v);
    return lfsr_next(v);
  endfunction
`else
  localparam logic [DATA_W-1:0] C_SEED_EFF = SEED;

  function automatic logic [DATA_W-1:0] step_fn(input logic [DATA_W-1:0] v);
    return v + STEP;
  endfunction
`endif

  logic [DATA_W-1:0] r_pattern;

  // Next-beat pattern register: reload at run start, step once per beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pattern <= C_SEED_EFF;
    end else if (i_load) begin
      r_pattern <= step_fn(C_SEED_EFF);
    end else if (i_advance) begin
      r_pattern <= step_fn(r_pattern);
    end else begin
      r_pattern <= r_pattern;
    end
  end

  assign o_seed  = C_SEED_EFF;
  assign o_value = r_pattern;

endmodule

// File: rtl/data_producer.sv
// Burst pattern source for the 8-bit valid-only data interface.
// On a start request emits NUM_BURSTS bursts of BURST_LEN beats separated by
// GAP_CYCLES idle cycles, then pulses o_Done. All outputs are registered.
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   bus     data_producer_if.master (i_Start, i_Stop in; data/valid/busy/done/count out)
// Build option: DATA_PRODUCER_LFSR_EN switches the data pattern from a STEP
// counter to an 8-bit LFSR (see data_pattern_gen).
module data_producer
  import data_producer_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned NUM_BURSTS = 4,
  parameter logic [7:0]  SEED       = 8'h00,
  parameter logic [7:0]  STEP       = 8'h01
) (
  input  logic                   clk,
  input  logic                   resetn,
  data_producer_if.master        bus
);

  // 9-bit counters leave headroom above the 255 maximum parameter values.
  localparam logic [8:0] C_LEN = 9'(BURST_LEN);
  localparam logic [8:0] C_GAP = 9'(GAP_CYCLES);
  localparam logic [8:0] C_NUM = 9'(NUM_BURSTS);

  producer_state_t       r_state;
  logic [DATA_W-1:0]     r_data;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [BEAT_CNT_W-1:0] r_beat_count;
  logic [8:0]            r_beat_in_burst;  // beats presented in current burst
  logic [8:0]            r_gap_cnt;        // gap cycles presented so far
  logic [8:0]            r_burst_cnt;      // bursts completed

  logic              w_load;
  logic              w_emit;
  logic              w_burst_end;
  logic              w_last_burst;
  logic [DATA_W-1:0] w_seed;
  logic [DATA_W-1:0] w_pattern;

  // Decide whether the coming edge starts a run or presents another beat.
  always_comb begin
    w_load       = 1'b0;
    w_emit       = 1'b0;
    w_burst_end  = (r_beat_in_burst == C_LEN);
    w_last_burst = ((r_burst_cnt + 9'd1) == C_NUM);
    if (bus.i_Stop) begin
      w_load = 1'b0;
      w_emit = 1'b0;
    end else begin
      case (r_state)
        IDLE:    w_load = bus.i_Start;
        BURST:   w_emit = !w_burst_end || (!w_last_burst && (C_GAP == 9'd0));
        GAP:     w_emit = (r_gap_cnt == C_GAP);
        DONE:    w_emit = 1'b0;
        default: w_emit = 1'b0;
      endcase
    end
  end

  data_pattern_gen #(
    .SEED (SEED),
    .STEP (STEP)
  ) u_pattern (
    .clk       (clk),
    .resetn    (resetn),
    .i_load    (w_load),
    .i_advance (w_emit),
    .o_seed    (w_seed),
    .o_value   (w_pattern)
  );

  // Run-control FSM with registered outputs. The output registers describe
  // the cycle after the edge, so the first beat appears right after start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= IDLE;
      r_data          <= 8'h00;
      r_valid         <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_beat_count    <= 16'h0000;
      r_beat_in_burst <= 9'd0;
      r_gap_cnt       <= 9'd0;
      r_burst_cnt     <= 9'd0;
    end else begin
      // A beat counts once it has been on the bus across a clock edge,
      // including the beat that is on the bus when a stop is sampled.
      if (w_load) begin
        r_beat_count <= 16'h0000;
      end else if (r_valid) begin
        r_beat_count <= r_beat_count + 16'h0001;
      end else begin
        r_beat_count <= r_beat_count;
      end

      if (bus.i_Stop) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_done <= 1'b0;
            if (w_load) begin
              r_state         <= BURST;
              r_valid         <= 1'b1;
              r_busy          <= 1'b1;
              r_data          <= w_seed;
              r_beat_in_burst <= 9'd1;
              r_gap_cnt       <= 9'd0;
              r_burst_cnt     <= 9'd0;
            end
          end
          BURST: begin
            if (w_emit) begin
              r_valid <= 1'b1;
              r_data  <= w_pattern;
              if (w_burst_end) begin
                r_beat_in_burst <= 9'd1;
                r_burst_cnt     <= r_burst_cnt + 9'd1;
              end else begin
                r_beat_in_burst <= r_beat_in_burst + 9'd1;
              end
            end else if (w_last_burst) begin
              r_state     <= DONE;
              r_valid     <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_burst_cnt <= r_burst_cnt + 9'd1;
            end else begin
              r_state     <= GAP;
              r_valid     <= 1'b0;
              r_gap_cnt   <= 9'd1;
              r_burst_cnt <= r_burst_cnt + 9'd1;
            end
          end
          GAP: begin
            if (w_emit) begin
              r_state         <= BURST;
              r_valid         <= 1'b1;
              r_data          <= w_pattern;
              r_beat_in_burst <= 9'd1;
              r_gap_cnt       <= 9'd0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 9'd1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_Output_Data = r_data;
  assign bus.o_Data_Valid  = r_valid;
  assign bus.o_Busy        = r_busy;
  assign bus.o_Done        = r_done;
  assign bus.o_Beat_Count  = r_beat_count;

endmodule

// File: tb/tb_data_producer.sv
// Self-checking bench for data_producer. Four instances with different
// parameter sets; a schedule model computes, for every cycle after a start,
// whether a beat, a gap or the done pulse is expected and which data value.
module tb_data_producer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  data_producer_if ifc0 ();
  data_producer_if ifc1 ();
  data_producer_if ifc2 ();
  data_producer_if ifc3 ();

  logic start_v [4];
  logic stop_v  [4];
  assign ifc0.i_Start = start_v[0];  assign ifc0.i_Stop = stop_v[0];
  assign ifc1.i_Start = start_v[1];  assign ifc1.i_Stop = stop_v[1];
  assign ifc2.i_Start = start_v[2];  assign ifc2.i_Stop = stop_v[2];
  assign ifc3.i_Start = start_v[3];  assign ifc3.i_Stop = stop_v[3];

  data_producer u0 (.clk(clk), .resetn(resetn), .bus(ifc0.master));
  data_producer #(.BURST_LEN(4), .GAP_CYCLES(0), .NUM_BURSTS(3)) u1 (.clk(clk), .resetn(resetn), .bus(ifc1.master));
  data_producer #(.BURST_LEN(4), .NUM_BURSTS(1), .SEED(8'hFE), .STEP(8'h01)) u2 (.clk(clk), .resetn(resetn), .bus(ifc2.master));
  data_producer #(.BURST_LEN(5), .GAP_CYCLES(1), .NUM_BURSTS(3), .SEED(8'h3C), .STEP(8'h25)) u3 (.clk(clk), .resetn(resetn), .bus(ifc3.master));

  int         p_len  [4] = '{16, 4, 4, 5};
  int         p_gap  [4] = '{3, 0, 3, 1};
  int         p_num  [4] = '{4, 3, 1, 3};
  logic [7:0] p_seed [4] = '{8'h00, 8'h00, 8'hFE, 8'h3C};
  logic [7:0] p_step [4] = '{8'h01, 8'h01, 8'h01, 8'h25};

  int         sel;
  logic [7:0] ob_data;
  logic       ob_valid, ob_busy, ob_done;
  logic [15:0] ob_cnt;

  always_comb begin
    case (sel)
      1: begin ob_data = ifc1.o_Output_Data; ob_valid = ifc1.o_Data_Valid; ob_busy = ifc1.o_Busy; ob_done = ifc1.o_Done; ob_cnt = ifc1.o_Beat_Count; end
      2: begin ob_data = ifc2.o_Output_Data; ob_valid = ifc2.o_Data_Valid; ob_busy = ifc2.o_Busy; ob_done = ifc2.o_Done; ob_cnt = ifc2.o_Beat_Count; end
      3: begin ob_data = ifc3.o_Output_Data; ob_valid = ifc3.o_Data_Valid; ob_busy = ifc3.o_Busy; ob_done = ifc3.o_Done; ob_cnt = ifc3.o_Beat_Count; end
      default: begin ob_data = ifc0.o_Output_Data; ob_valid = ifc0.o_Data_Valid; ob_busy = ifc0.o_Busy; ob_done = ifc0.o_Done; ob_cnt = ifc0.o_Beat_Count; end
    endcase
  end

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] exp_last [4];
  int         exp_cnt  [4];

  // Reference data value of beat number k of a run.
  function automatic logic [7:0] ref_pattern(input logic [7:0] seed, input logic [7:0] step, input int k);
    logic [7:0] v;
`ifdef DATA_PRODUCER_LFSR_EN
    v = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
    v = 8'((int'(seed) + k * int'(step)) % 256);
`endif
    return v;
  endfunction

  // Cycle index (1 = first cycle after the start edge) of the last beat.
  function automatic int last_beat_t(input int s);
    return p_len[s] * p_num[s] + (p_num[s] - 1) * p_gap[s];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic eb, input logic ed, input logic [7:0] edata, input int ecnt);
    check({tag, ".valid"}, 32'(ob_valid), 32'(ev));
    check({tag, ".busy"},  32'(ob_busy),  32'(eb));
    check({tag, ".done"},  32'(ob_done),  32'(ed));
    check({tag, ".data"},  32'(ob_data),  32'(edata));
    check({tag, ".count"}, 32'(ob_cnt),   32'(ecnt & 32'h0000FFFF));
  endtask

  // Start a run on instance s and check every cycle until a few cycles past done.
  // stop_at > 0 raises i_Stop during that cycle; rnd adds ignored start pulses.
  task automatic run_stream(input int s, input int stop_at, input bit rnd);
    int  period, end_t, b, w;
    bit  stopped;
    logic ev, eb, ed;
    sel = s;
    period = p_len[s] + p_gap[s];
    end_t = last_beat_t(s);
    stopped = 1'b0;
    @(negedge clk); start_v[s] = 1'b1;
    @(negedge clk); start_v[s] = 1'b0;
    exp_cnt[s] = 0;
    for (int t = 1; t <= end_t + 3; t++) begin
      ev = 1'b0; eb = 1'b0; ed = 1'b0;
      if (!stopped) begin
        if (t <= end_t) begin
          b = (t - 1) / period;
          w = (t - 1) % period;
          eb = 1'b1;
          if (w < p_len[s]) begin
            ev = 1'b1;
            exp_last[s] = ref_pattern(p_seed[s], p_step[s], b * p_len[s] + w);
          end
        end else if (t == end_t + 1) begin
          ed = 1'b1;
        end
      end
      check_all($sformatf("run%0d.t%0d", s, t), ev, eb, ed, exp_last[s], exp_cnt[s]);
      if (ev) exp_cnt[s]++;
      stop_v[s] = (t == stop_at);
      if (t == stop_at) stopped = 1'b1;
      start_v[s] = rnd && (t >= 2) && (t <= end_t) && (stop_at == 0 || t < stop_at)
                   && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    start_v[s] = 1'b0;
    stop_v[s] = 1'b0;
  endtask

  initial begin
    int s, st;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0; stop_v[i] = 1'b0; exp_last[i] = 8'h00; exp_cnt[i] = 0;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = i; #1;
      check_all($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 8'h00, 0);
    end
    resetn = 1'b1;
    repeat (6) @(negedge clk);

    // Directed runs: defaults, back-to-back bursts, wrap, odd step.
    run_stream(0, 0, 1'b0);
    run_stream(1, 0, 1'b0);
    run_stream(2, 0, 1'b0);
    run_stream(3, 0, 1'b1);

    // Stop on the 5th beat of burst 2, then a clean restart.
    run_stream(0, 16 + 3 + 5, 1'b0);
    run_stream(0, 0, 1'b1);

    // Start and stop together while idle: nothing happens.
    sel = 0;
    @(negedge clk); start_v[0] = 1'b1; stop_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; stop_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_all("startstop", 1'b0, 1'b0, 1'b0, exp_last[0], exp_cnt[0]);
      @(negedge clk);
    end

    // Randomized runs with optional random stop.
    for (int r = 0; r < 4; r++) begin
      s = int'($urandom_range(0, 3));
      st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, last_beat_t(s))) : 0;
      run_stream(s, st, 1'b1);
    end

    // Reset in the middle of the first gap.
    sel = 0;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("gap.busy",  32'(ob_busy),  32'd1);
    check("gap.valid", 32'(ob_valid), 32'd0);
    resetn = 1'b0;
    #1;
    check_all("midgap_reset", 1'b0, 1'b0, 1'b0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin exp_last[i] = 8'h00; exp_cnt[i] = 0; end
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all("post_reset", 1'b0, 1'b0, 1'b0, 8'h00, 0);
    end
    run_stream(0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
